// File: rtl/conv_layer_parallel.sv
// conv_layer_parallel
//   Multi-filter 2-D convolution layer. K filters of D x F x F are applied to a
//   D x H x W flat-packed image with a configurable stride. P MAC lanes work on
//   P filters at once; the K/P filter groups run one after another. Each output
//   is sat(acc >>> FRAC), with optional ReLU, in signed fixed point.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : asynchronous, active-high
//   start      : run request, sampled only while idle
//   image      : element (d,y,x) at index d*H*W + y*W + x, DATA_WIDTH bits each
//   filters    : element (k,d,fy,fx) at index k*D*F*F + d*F*F + fy*F + fx
//   busy       : run in progress
//   done       : one-cycle pulse after the final write of a run
//   outputConv : registered results, element (k,r,c) at index k*OH*OW + r*OW + c
//
// K must be a multiple of P. image and filters must be held stable while busy.

module conv_layer_parallel #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAC       = 8,
    parameter int unsigned D          = 1,
    parameter int unsigned H          = 30,
    parameter int unsigned W          = 30,
    parameter int unsigned F          = 3,
    parameter int unsigned K          = 6,
    parameter int unsigned P          = 2,
    parameter int unsigned STRIDE     = 1,
    parameter int unsigned RELU       = 0
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [D*H*W*DATA_WIDTH-1:0]           image,
    input  logic [K*D*F*F*DATA_WIDTH-1:0]         filters,
    output logic                                  busy,
    output logic                                  done,
    output logic [K*((H-F)/STRIDE+1)*((W-F)/STRIDE+1)*DATA_WIDTH-1:0] outputConv
);

    localparam int unsigned T   = D * F * F;
    localparam int unsigned G   = K / P;
    localparam int unsigned OH  = (H - F) / STRIDE + 1;
    localparam int unsigned OW  = (W - F) / STRIDE + 1;
    localparam int unsigned PW  = 2 * DATA_WIDTH;
    // clog2(T) headroom bits: the sum of T full-scale products cannot overflow
    localparam int unsigned AW  = PW + $clog2(T);
    localparam int unsigned GW  = (G  > 1) ? $clog2(G)  : 1;
    localparam int unsigned RW  = (OH > 1) ? $clog2(OH) : 1;
    localparam int unsigned CW  = (OW > 1) ? $clog2(OW) : 1;
    localparam int unsigned TDW = (D  > 1) ? $clog2(D)  : 1;
    localparam int unsigned FW  = (F  > 1) ? $clog2(F)  : 1;

    localparam logic signed [AW-1:0] SAT_MAX =
        {{(AW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN =
        {{(AW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StMac, StWrite} state_t;

    state_t                        state;
    logic [GW-1:0]                 g_cnt;
    logic [RW-1:0]                 r_cnt;
    logic [CW-1:0]                 c_cnt;
    logic [TDW-1:0]                d_cnt;
    logic [FW-1:0]                 fy_cnt;
    logic [FW-1:0]                 fx_cnt;
    logic signed [AW-1:0]          acc     [P];

    logic signed [DATA_WIDTH-1:0]  pixel;
    logic signed [DATA_WIDTH-1:0]  coef    [P];
    logic signed [PW-1:0]          prod    [P];
    logic signed [AW-1:0]          shifted [P];
    logic signed [DATA_WIDTH-1:0]  result  [P];
    int unsigned                   out_idx [P];
    int unsigned                   pix_idx;
    int unsigned                   tap_idx;
    int unsigned                   flt_idx;

    // Datapath: one shared pixel per tap, one filter coefficient per lane.
    always_comb begin
        coef    = '{default: '0};
        prod    = '{default: '0};
        shifted = '{default: '0};
        result  = '{default: '0};
        out_idx = '{default: 0};
        flt_idx = 0;
        pix_idx = 32'(d_cnt) * H * W
                + (32'(r_cnt) * STRIDE + 32'(fy_cnt)) * W
                + 32'(c_cnt) * STRIDE + 32'(fx_cnt);
        tap_idx = 32'(d_cnt) * F * F + 32'(fy_cnt) * F + 32'(fx_cnt);
        pixel   = image[pix_idx*DATA_WIDTH +: DATA_WIDTH];
        for (int unsigned l = 0; l < P; l++) begin
            flt_idx    = (32'(g_cnt) * P + l) * T + tap_idx;
            coef[l]    = filters[flt_idx*DATA_WIDTH +: DATA_WIDTH];
            prod[l]    = PW'(pixel) * PW'(coef[l]);
            shifted[l] = acc[l] >>> FRAC;
            if (shifted[l] > SAT_MAX) begin
                result[l] = SAT_MAX[DATA_WIDTH-1:0];
            end else if (shifted[l] < SAT_MIN) begin
                result[l] = SAT_MIN[DATA_WIDTH-1:0];
            end else begin
                result[l] = shifted[l][DATA_WIDTH-1:0];
            end
            // ReLU follows saturation
            if (RELU != 0 && result[l][DATA_WIDTH-1]) begin
                result[l] = '0;
            end
            out_idx[l] = (32'(g_cnt) * P + l) * OH * OW + 32'(r_cnt) * OW + 32'(c_cnt);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            busy       <= 1'b0;
            done       <= 1'b0;
            g_cnt      <= '0;
            r_cnt      <= '0;
            c_cnt      <= '0;
            d_cnt      <= '0;
            fy_cnt     <= '0;
            fx_cnt     <= '0;
            outputConv <= '0;
            for (int unsigned l = 0; l < P; l++) begin
                acc[l] <= '0;
            end
        end else begin
            case (state)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        state  <= StMac;
                        busy   <= 1'b1;
                        g_cnt  <= '0;
                        r_cnt  <= '0;
                        c_cnt  <= '0;
                        d_cnt  <= '0;
                        fy_cnt <= '0;
                        fx_cnt <= '0;
                        for (int unsigned l = 0; l < P; l++) begin
                            acc[l] <= '0;
                        end
                    end
                end

                StMac: begin
                    for (int unsigned l = 0; l < P; l++) begin
                        acc[l] <= acc[l] + AW'(prod[l]);
                    end
                    // Tap order d, fy, fx with fx fastest
                    if (fx_cnt == FW'(F - 1)) begin
                        fx_cnt <= '0;
                        if (fy_cnt == FW'(F - 1)) begin
                            fy_cnt <= '0;
                            if (d_cnt == TDW'(D - 1)) begin
                                d_cnt <= '0;
                                state <= StWrite;
                            end else begin
                                d_cnt <= d_cnt + TDW'(1);
                            end
                        end else begin
                            fy_cnt <= fy_cnt + FW'(1);
                        end
                    end else begin
                        fx_cnt <= fx_cnt + FW'(1);
                    end
                end

                StWrite: begin
                    for (int unsigned l = 0; l < P; l++) begin
                        outputConv[out_idx[l]*DATA_WIDTH +: DATA_WIDTH] <= result[l];
                        acc[l] <= '0;
                    end
                    state <= StMac;
                    // Position order: column, then row, then filter group
                    if (c_cnt == CW'(OW - 1)) begin
                        c_cnt <= '0;
                        if (r_cnt == RW'(OH - 1)) begin
                            r_cnt <= '0;
                            if (g_cnt == GW'(G - 1)) begin
                                g_cnt <= '0;
                                state <= StIdle;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                g_cnt <= g_cnt + GW'(1);
                            end
                        end else begin
                            r_cnt <= r_cnt + RW'(1);
                        end
                    end else begin
                        c_cnt <= c_cnt + CW'(1);
                    end
                end

                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
